inst_fetch: RTL and testbench

- Fetch-side initiator for the instruction cache. Owns the PC and probes the icache each cycle.
- On a miss, fetches the 32-bit instruction byte by byte over the byte-wide memory port, writes it into the icache and delivers it to the IF/ID register.
- Handles pipeline stall and branch redirect.

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch.sv | 124 ++++++++++++
 tb/tb_inst_fetch.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// bus widths and common constants.
package inst_fetch_pkg;

  localparam int unsigned INST_W         = 32;
  localparam int unsigned IF_ADDR_W      = 17;
  localparam int unsigned BYTES_PER_INST = 4;
  localparam int unsigned CNT_W          = 3;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic              ENABLE    = 1'b1;
  localparam logic              DISABLE   = 1'b0;

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, probes the icache every cycle, and on a
// miss fetches the word byte-by-byte over the memory port, fills the icache
// and hands the instruction to IF/ID.
// Ports:
//   clk, rst             clock, async active-low reset
//   stall_i              downstream stall, IF/ID output registers hold
//   branch_i/_target_i   one-cycle redirect (highest priority)
//   icache_read_*        probe interface (combinational hit/data back)
//   icache_write_*       fill strobe, address and word
//   mem_*                byte-wide read port (data one cycle after grant)
//   inst_valid_o/inst_o/inst_pc_o  registered IF/ID payload
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = IF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [31:0]       branch_target_i,
  output logic              icache_read_o,
  output logic [ADDR_W-1:0] icache_read_addr_o,
  input  logic              icache_hit_i,
  input  logic [INST_W-1:0] icache_inst_i,
  output logic              icache_write_o,
  output logic [ADDR_W-1:0] icache_write_addr_o,
  output logic [INST_W-1:0] icache_write_inst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_grant_i,
  input  logic [7:0]        mem_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [31:0]       inst_pc_o
);

  fetch_state_e      state;
  logic [31:0]       pc;
  logic [CNT_W-1:0]  issue_cnt;
  logic [1:0]        recv_cnt;
  logic              pending;
  logic [INST_W-1:0] word;

  // Interface strobes are decoded straight from state so that an async reset
  // drops mem_req_o immediately.
  assign icache_read_o       = (state != ST_FILL);
  assign icache_read_addr_o  = pc[ADDR_W-1:0];
  assign mem_req_o           = (state == ST_FILL) && (issue_cnt < CNT_W'(BYTES_PER_INST));
  assign mem_addr_o          = {pc[ADDR_W-1:2], issue_cnt[1:0]};
  // A redirect in the COMMIT cycle discards the word, so the fill is suppressed.
  assign icache_write_o      = (state == ST_COMMIT) && !branch_i;
  assign icache_write_addr_o = pc[ADDR_W-1:0];
  assign icache_write_inst_o = word;

  // Fetch FSM, byte assembler and IF/ID output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_LOOKUP;
      pc           <= RESET_PC;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      pending      <= DISABLE;
      word         <= ZERO_WORD;
      inst_valid_o <= DISABLE;
      inst_o       <= ZERO_WORD;
      inst_pc_o    <= '0;
    end else if (branch_i) begin
      state        <= ST_LOOKUP;
      pc           <= branch_target_i;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      pending      <= DISABLE;
      inst_valid_o <= DISABLE;
    end else begin
      unique case (state)
        ST_LOOKUP: begin
          if (icache_hit_i) begin
            if (!stall_i) begin
              inst_o       <= icache_inst_i;
              inst_pc_o    <= pc;
              inst_valid_o <= ENABLE;
              pc           <= pc + 32'd4;
            end
          end else begin
            state     <= ST_FILL;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pending   <= DISABLE;
            if (!stall_i) inst_valid_o <= DISABLE;
          end
        end
        ST_FILL: begin
          if (!stall_i) inst_valid_o <= DISABLE;
          if (mem_req_o && mem_grant_i) issue_cnt <= issue_cnt + CNT_W'(1);
          // pending marks that a granted byte lands on mem_data_i this cycle
          pending <= mem_req_o && mem_grant_i;
          if (pending) begin
            word[{recv_cnt, 3'b000} +: 8] <= mem_data_i;
            recv_cnt <= recv_cnt + 2'd1;
            if (recv_cnt == 2'd3) state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // The icache forwards the same-cycle fill, so this normally hits.
          if (!stall_i) begin
            if (icache_hit_i) begin
              inst_o       <= icache_inst_i;
              inst_pc_o    <= pc;
              inst_valid_o <= ENABLE;
              pc           <= pc + 32'd4;
            end else begin
              inst_valid_o <= DISABLE;
            end
          end
          state <= ST_LOOKUP;
        end
        default: state <= ST_LOOKUP;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a byte memory and a small icache model
// drive the DUT; a program-order PC model checks every delivered instruction,
// probe/fill addresses and icache writes, alongside directed literal checks.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        icache_read_o;
  logic [16:0] icache_read_addr_o;
  logic        icache_hit_i;
  logic [31:0] icache_inst_i;
  logic        icache_write_o;
  logic [16:0] icache_write_addr_o;
  logic [31:0] icache_write_inst_o;
  logic        mem_req_o;
  logic [16:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  inst_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_i             (stall_i),
    .branch_i            (branch_i),
    .branch_target_i     (branch_target_i),
    .icache_read_o       (icache_read_o),
    .icache_read_addr_o  (icache_read_addr_o),
    .icache_hit_i        (icache_hit_i),
    .icache_inst_i       (icache_inst_i),
    .icache_write_o      (icache_write_o),
    .icache_write_addr_o (icache_write_addr_o),
    .icache_write_inst_o (icache_write_inst_o),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_grant_i         (mem_grant_i),
    .mem_data_i          (mem_data_i),
    .inst_valid_o        (inst_valid_o),
    .inst_o              (inst_o),
    .inst_pc_o           (inst_pc_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int write_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: word 0 is addi a0,zero,1; the rest is a hash of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] wa;
    wa = {15'd0, a[16:2], 2'b00};
    if (wa == 32'd0) return 32'h0010_0513;
    return (wa * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [7:0] byte_at(input logic [16:0] a);
    logic [31:0] w;
    w = word_at({15'd0, a});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Icache model: small direct-indexed store plus same-cycle write forwarding.
  logic        ic_valid [0:127];
  logic [31:0] ic_data  [0:127];

  always_comb begin
    icache_hit_i  = 1'b0;
    icache_inst_i = 32'h0;
    if (icache_read_o) begin
      if (icache_write_o && icache_write_addr_o == icache_read_addr_o) begin
        icache_hit_i  = 1'b1;
        icache_inst_i = icache_write_inst_o;
      end else if (ic_valid[icache_read_addr_o[8:2]]) begin
        icache_hit_i  = 1'b1;
        icache_inst_i = ic_data[icache_read_addr_o[8:2]];
      end
    end
  end

  // Edge capture of bench-driven controls plus icache update.
  logic        stall_q = 1'b0, branch_q = 1'b0, rst_q = 1'b0, grant_q = 1'b0;
  logic [31:0] target_q = 32'h0;
  initial begin
    for (int i = 0; i < 128; i++) begin ic_valid[i] = 1'b0; ic_data[i] = 32'h0; end
    for (int i = 1; i < 8; i++) begin ic_valid[i] = 1'b1; ic_data[i] = word_at(32'(i) * 32'd4); end
    forever begin
      @(posedge clk);
      stall_q  <= stall_i;
      branch_q <= branch_i;
      target_q <= branch_target_i;
      rst_q    <= rst;
      grant_q  <= mem_req_o && mem_grant_i;
      if (rst && icache_write_o) begin
        ic_valid[icache_write_addr_o[8:2]] <= 1'b1;
        ic_data[icache_write_addr_o[8:2]]  <= icache_write_inst_o;
      end
    end
  end

  // Memory arbiter/responder: grant from a pattern queue (default 1), data the
  // cycle after the grant, junk otherwise.
  bit          gq[$];
  logic        last_grant = 1'b0;
  logic [16:0] last_addr  = '0;
  initial begin
    bit g;
    mem_grant_i = 1'b0;
    mem_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      mem_data_i = last_grant ? byte_at(last_addr) : 8'hEE;
      g = 1'b1;
      if (mem_req_o && gq.size() > 0) g = gq.pop_front();
      mem_grant_i = mem_req_o && g;
      last_grant  = mem_grant_i;
      last_addr   = mem_addr_o;
    end
  end

  // Program-order model: next PC to deliver, every instruction equals memory.
  logic [31:0] exp_pc = 32'h0;
  logic        prev_valid = 1'b0, prev_req = 1'b0, have_prev = 1'b0;
  logic [31:0] prev_inst = 32'h0, prev_pc = 32'h0;
  logic [16:0] prev_addr = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_q) begin
        exp_pc    = 32'h0;
        have_prev = 1'b0;
        prev_req  = 1'b0;
      end else begin
        if (branch_q) begin
          chk("model_branch_flush", 32'(inst_valid_o), 32'd0);
          exp_pc = target_q;
        end else if (stall_q) begin
          if (have_prev) begin
            chk("model_stall_valid", 32'(inst_valid_o), 32'(prev_valid));
            chk("model_stall_inst", inst_o, prev_inst);
            chk("model_stall_pc", inst_pc_o, prev_pc);
          end
        end else if (inst_valid_o) begin
          chk("model_deliver_pc", inst_pc_o, exp_pc);
          chk("model_deliver_inst", inst_o, word_at(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
        if (icache_read_o)
          chk("model_probe_addr", 32'(icache_read_addr_o), 32'(exp_pc[16:0]));
        if (mem_req_o) begin
          chk("model_fill_word", 32'(mem_addr_o[16:2]), 32'(exp_pc[16:2]));
          if (prev_req && !grant_q)
            chk("model_addr_hold", 32'(mem_addr_o), 32'(prev_addr));
          if (prev_req && grant_q)
            chk("model_addr_step", 32'(mem_addr_o[1:0]), 32'(2'(prev_addr[1:0] + 2'd1)));
        end
        if (icache_write_o) begin
          write_cnt++;
          chk("model_wr_addr", 32'(icache_write_addr_o), 32'(exp_pc[16:0]));
          chk("model_wr_data", icache_write_inst_o, word_at(exp_pc));
        end
        prev_valid = inst_valid_o;
        prev_inst  = inst_o;
        prev_pc    = inst_pc_o;
        prev_req   = mem_req_o;
        prev_addr  = mem_addr_o;
        have_prev  = 1'b1;
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    int n, reqs, w0;
    rst = 1'b0; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_wr", 32'(icache_write_o), 32'd0);
    chk("rst_rd", 32'(icache_read_o), 32'd1);
    chk("rst_rd_addr", 32'(icache_read_addr_o), 32'd0);

    // Cold miss at PC 0 with continuous grant.
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); #1;
      if (c <= 4) begin
        chk("cold_req", 32'(mem_req_o), 32'd1);
        chk("cold_addr", 32'(mem_addr_o), 32'(c - 1));
      end else if (c == 5) begin
        chk("cold_req_done", 32'(mem_req_o), 32'd0);
      end
      chk("cold_wr_strobe", 32'(icache_write_o), (c == 6) ? 32'd1 : 32'd0);
      if (c == 6) begin
        chk("cold_wr_addr", 32'(icache_write_addr_o), 32'd0);
        chk("cold_wr_data", icache_write_inst_o, 32'h0010_0513);
      end
      if (c == 7) begin
        chk("cold_valid", 32'(inst_valid_o), 32'd1);
        chk("cold_inst", inst_o, 32'h0010_0513);
        chk("cold_inst_pc", inst_pc_o, 32'd0);
      end
    end

    // Hit stream with a three-cycle stall after PC 4.
    @(negedge clk); #1;
    chk("hit_pc4", inst_pc_o, 32'h4);
    chk("hit_valid", 32'(inst_valid_o), 32'd1);
    stall_i = 1'b1;
    for (int c = 9; c <= 11; c++) begin
      @(negedge clk); #1;
      chk("stall_pc_frozen", inst_pc_o, 32'h4);
      chk("stall_probe_frozen", 32'(icache_read_addr_o), 32'h8);
    end
    stall_i = 1'b0;
    @(negedge clk); #1;
    chk("resume_pc8", inst_pc_o, 32'h8);
    @(negedge clk); #1;
    chk("resume_pcc", inst_pc_o, 32'hC);
    chk("resume_inst_c", inst_o, word_at(32'hC));

    // Grant gaps on the 0x20 fill.
    gq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    w0 = write_cnt; n = 0; reqs = 0;
    do begin
      @(negedge clk); #1; n++;
      if (mem_req_o) reqs++;
    end while (!icache_write_o && n < 40);
    chk("gap_write_seen", 32'(icache_write_o), 32'd1);
    chk("gap_wr_addr", 32'(icache_write_addr_o), 32'h20);
    chk("gap_req_cycles", 32'(reqs), 32'd7);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(inst_valid_o && inst_pc_o == 32'h20) && n < 10);
    chk("gap_deliver_20", inst_pc_o, 32'h20);
    chk("gap_one_write", 32'(write_cnt - w0), 32'd1);

    // Branch to 0x100 after two grants of the 0x24 fill.
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(mem_req_o && mem_addr_o[1:0] == 2'd2) && n < 10);
    chk("br_two_grants", 32'(mem_addr_o), 32'h26);
    w0 = write_cnt;
    branch_i = 1'b1; branch_target_i = 32'h100;
    @(negedge clk);
    branch_i = 1'b0;
    #1;
    chk("br_valid", 32'(inst_valid_o), 32'd0);
    chk("br_probe", 32'(icache_read_o), 32'd1);
    chk("br_probe_addr", 32'(icache_read_addr_o), 32'h100);
    chk("br_no_req", 32'(mem_req_o), 32'd0);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(inst_valid_o && inst_pc_o == 32'h100) && n < 20);
    chk("br_deliver_100", inst_pc_o, 32'h100);
    chk("br_inst_100", inst_o, word_at(32'h100));
    chk("br_only_target_written", 32'(write_cnt - w0), 32'd1);
    chk("br_no_partial_fill", 32'(ic_valid[9]), 32'd0);

    // Async reset in the middle of the 0x104 fill.
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!mem_req_o && n < 10);
    chk("ar_in_fill", 32'(mem_req_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_req_drop", 32'(mem_req_o), 32'd0);
    chk("ar_valid", 32'(inst_valid_o), 32'd0);
    chk("ar_probe_addr", 32'(icache_read_addr_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("ar_restart_valid", 32'(inst_valid_o), 32'd1);
    chk("ar_restart_pc", inst_pc_o, 32'd0);
    chk("ar_restart_inst", inst_o, 32'h0010_0513);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
